string_serializer: RTL and testbench

STRING_SERIALIZER -- requirements
Module: string_serializer

---
 rtl/string_serializer.sv | 153 +++++++++++++++
 tb/tb_string_serializer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/string_serializer.sv
// string_serializer: loads a parallel word and shifts it out MSB first as a
// registered serial stream, LEN+1 bits long, for a downstream string detector.
//
// Ports
//   CP       in   clock, all state changes on the rising edge
//   RST      in   asynchronous active-high reset
//   LOAD     in   start request, honoured only in IDLE or FIN
//   DATA     in   WIDTH-bit parallel word, sent MSB first
//   LEN      in   CW-bit bit count minus one, clamped to WIDTH-1
//   D        out  registered serial bit
//   BUSY     out  high while a word is being shifted
//   DONE     out  one-cycle pulse after the last bit
//   BIT_CNT  out  bits still to send after the current one
//   LOOP     in   (only with STRING_SERIALIZER_LOOP_EN) repeat the saved word
//
// Optional feature macro: STRING_SERIALIZER_LOOP_EN
module string_serializer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = 3
) (
  input  logic             CP,
  input  logic             RST,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] DATA,
  input  logic [CW-1:0]    LEN,
`ifdef STRING_SERIALIZER_LOOP_EN
  input  logic             LOOP,
`endif
  output logic             D,
  output logic             BUSY,
  output logic             DONE,
  output logic [CW-1:0]    BIT_CNT
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  localparam logic [CW-1:0] LenMax = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic             d_q, d_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    len_clamped;

`ifdef STRING_SERIALIZER_LOOP_EN
  logic [WIDTH-1:0] saved_data_q, saved_data_d;
  logic [CW-1:0]    saved_len_q, saved_len_d;
`endif

  // Compare in 32 bits so WIDTH == 2**CW does not wrap the limit.
  assign len_clamped = (32'(LEN) >= WIDTH) ? LenMax : LEN;

  // State and output registers.
  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      d_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      sr_q    <= '0;
`ifdef STRING_SERIALIZER_LOOP_EN
      saved_data_q <= '0;
      saved_len_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
`ifdef STRING_SERIALIZER_LOOP_EN
      saved_data_q <= saved_data_d;
      saved_len_q  <= saved_len_d;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    busy_d  = busy_q;
    done_d  = done_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
`ifdef STRING_SERIALIZER_LOOP_EN
    saved_data_d = saved_data_q;
    saved_len_d  = saved_len_q;
`endif
    case (state_q)
      IDLE, FIN: begin
        if (LOAD) begin
          state_d = SHIFT;
          d_d     = DATA[WIDTH-1];
          sr_d    = {DATA[WIDTH-2:0], 1'b0};
          cnt_d   = len_clamped;
          busy_d  = 1'b1;
          done_d  = 1'b0;
`ifdef STRING_SERIALIZER_LOOP_EN
          saved_data_d = DATA;
          saved_len_d  = len_clamped;
`endif
        end else begin
          state_d = IDLE;
          d_d     = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          d_d   = sr_q[WIDTH-1];
          sr_d  = {sr_q[WIDTH-2:0], 1'b0};
          cnt_d = cnt_q - CW'(1);
`ifdef STRING_SERIALIZER_LOOP_EN
        end else if (LOOP) begin
          // Restart from the saved word on the last-bit edge: no gap, no DONE.
          d_d   = saved_data_q[WIDTH-1];
          sr_d  = {saved_data_q[WIDTH-2:0], 1'b0};
          cnt_d = saved_len_q;
`endif
        end else begin
          state_d = FIN;
          d_d     = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        d_d     = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  assign D       = d_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign BIT_CNT = cnt_q;

endmodule

// File: tb/tb_string_serializer.sv
// tb_string_serializer: directed self-checking bench for string_serializer.
// Built with CW=4 so LEN values above WIDTH-1 can exercise the clamp.
`timescale 1ns/1ps
module tb_string_serializer;

  localparam int unsigned W   = 8;
  localparam int unsigned CWP = 4;

  logic           CP;
  logic           RST;
  logic           LOAD;
  logic [W-1:0]   DATA;
  logic [CWP-1:0] LEN;
  logic           D;
  logic           BUSY;
  logic           DONE;
  logic [CWP-1:0] BIT_CNT;
`ifdef STRING_SERIALIZER_LOOP_EN
  logic           LOOP;
`endif

  int tests_run;
  int tests_failed;

  string_serializer #(.WIDTH(W), .CW(CWP)) dut (
    .CP      (CP),
    .RST     (RST),
    .LOAD    (LOAD),
    .DATA    (DATA),
    .LEN     (LEN),
`ifdef STRING_SERIALIZER_LOOP_EN
    .LOOP    (LOOP),
`endif
    .D       (D),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .BIT_CNT (BIT_CNT)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance past the next rising edge; samples taken here are 1 ns after it.
  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  task automatic load_word(input logic [W-1:0] data, input logic [CWP-1:0] len);
    LOAD = 1'b1;
    DATA = data;
    LEN  = len;
    tick();
    LOAD = 1'b0;
    DATA = '0;
    LEN  = '0;
  endtask

  // Check one expected serial bit per cycle (MSB-first string given as exp),
  // then the DONE cycle. Leaves time in the DONE (FIN) cycle.
  task automatic expect_bits(input string tag, input logic [W-1:0] exp, input int n);
    for (int i = 0; i < n; i++) begin
      check({tag, " D"},       32'(D),       32'(exp[W-1-i]));
      check({tag, " BUSY"},    32'(BUSY),    32'd1);
      check({tag, " BIT_CNT"}, 32'(BIT_CNT), 32'(n - 1 - i));
      check({tag, " DONE"},    32'(DONE),    32'd0);
      tick();
    end
    check({tag, " end D"},    32'(D),    32'd0);
    check({tag, " end BUSY"}, 32'(BUSY), 32'd0);
    check({tag, " end DONE"}, 32'(DONE), 32'd1);
  endtask

  task automatic expect_idle(input string tag);
    check({tag, " D"},       32'(D),       32'd0);
    check({tag, " BUSY"},    32'(BUSY),    32'd0);
    check({tag, " DONE"},    32'(DONE),    32'd0);
    check({tag, " BIT_CNT"}, 32'(BIT_CNT), 32'd0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    RST  = 1'b1;
    LOAD = 1'b0;
    DATA = '0;
    LEN  = '0;
`ifdef STRING_SERIALIZER_LOOP_EN
    LOOP = 1'b0;
`endif
    #12;
    expect_idle("reset");
    #2 RST = 1'b0;
    tick();
    expect_idle("idle");

    // 1101_0000, LEN=3: D=1,1,0,1 then DONE
    load_word(8'b1101_0000, 4'd3);
    expect_bits("w1101", 8'b1101_0000, 4);
    tick();
    expect_idle("after w1101");

    // A5, LEN=7: D=1,0,1,0,0,1,0,1, BIT_CNT 7..0
    load_word(8'hA5, 4'd7);
    expect_bits("wA5", 8'b1010_0101, 8);
    tick();
    expect_idle("after wA5");

    // LEN=0 sends exactly DATA[7]
    load_word(8'b1000_0000, 4'd0);
    expect_bits("len0", 8'b1000_0000, 1);
    tick();

    // LEN=12 clamps to 7: full 8 bits of 0x3C
    load_word(8'h3C, 4'd12);
    expect_bits("clamp", 8'b0011_1100, 8);
    tick();

    // LOAD during SHIFT ignored; original A5 sequence completes
    load_word(8'hA5, 4'd7);
    for (int i = 0; i < 8; i++) begin
      check("ign D", 32'(D), 32'(((8'hA5) >> (7 - i)) & 8'h01));
      check("ign BIT_CNT", 32'(BIT_CNT), 32'(7 - i));
      if (i == 2) begin
        LOAD = 1'b1;
        DATA = 8'h0F;
        LEN  = 4'd1;
      end else begin
        LOAD = 1'b0;
        DATA = '0;
        LEN  = '0;
      end
      tick();
    end
    check("ign DONE", 32'(DONE), 32'd1);
    tick();
    expect_idle("after ign");

    // Back-to-back: LOAD in FIN with 1000_0000 LEN=0
    load_word(8'b1101_0000, 4'd3);
    expect_bits("b2b first", 8'b1101_0000, 4);
    load_word(8'b1000_0000, 4'd0);
    check("b2b D",    32'(D),    32'd1);
    check("b2b BUSY", 32'(BUSY), 32'd1);
    check("b2b DONE", 32'(DONE), 32'd0);
    tick();
    check("b2b done2", 32'(DONE), 32'd1);
    check("b2b gapD",  32'(D),    32'd0);
    tick();
    expect_idle("after b2b");

    // Reset mid-word at cycle 2 between edges: abort, no DONE
    load_word(8'b1101_0000, 4'd3);
    tick();
    check("rst pre D", 32'(D), 32'd1);
    #2 RST = 1'b1;
    #1;
    expect_idle("rst async");
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst noDONE", 32'(DONE), 32'd0);
      check("rst noBUSY", 32'(BUSY), 32'd0);
    end
    // First edge after reset accepts LOAD
    load_word(8'b0110_0000, 4'd2);
    expect_bits("post rst", 8'b0110_0000, 3);
    tick();

`ifdef STRING_SERIALIZER_LOOP_EN
    // Loop: repeat 1,1,0,1 gaplessly, then drop LOOP and finish current pass
    LOOP = 1'b1;
    load_word(8'b1101_0000, 4'd3);
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 4; i++) begin
        check("loop D",    32'(D),    32'(((8'b1101_0000) >> (7 - i)) & 8'h01));
        check("loop BUSY", 32'(BUSY), 32'd1);
        check("loop DONE", 32'(DONE), 32'd0);
        if (p == 2 && i == 0) LOOP = 1'b0;
        tick();
      end
    end
    check("loop end DONE", 32'(DONE), 32'd1);
    check("loop end BUSY", 32'(BUSY), 32'd0);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
